any1_agen_seq: RTL and testbench

ANY1_AGEN_SEQ -- requirements
Module: any1_agen_seq

---
 rtl/any1_agen_seq_if.sv | 35 +++
 rtl/any1_agen_seq.sv | 146 ++++++++++++++
 tb/tb_any1_agen_seq.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/any1_agen_seq_if.sv
// Request/result bundle for the any1_agen_seq address generator.
// The master drives requests and the result-ready strobe.
// The slave (the generator) returns request-ready, the effective address and the status flags.
interface any1_agen_seq_if #(
    parameter int AWID = 64,
    parameter int CNTW = 8
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      mode;
    logic [AWID-1:0] base;
    logic [AWID-1:0] index;
    logic [AWID-1:0] disp;
    logic [2:0]      sc;
    logic [CNTW-1:0] cnt;
    logic [1:0]      size;
    logic [AWID-1:0] lim;
    logic            ea_valid;
    logic            ea_ready;
    logic [AWID-1:0] ea;
    logic            ea_last;
    logic            ea_misalign;
    logic            ea_oob;
    logic            busy;

    modport master (
        output req_valid, mode, base, index, disp, sc, cnt, size, lim, ea_ready,
        input  req_ready, ea_valid, ea, ea_last, ea_misalign, ea_oob, busy
    );

    modport slave (
        input  req_valid, mode, base, index, disp, sc, cnt, size, lim, ea_ready,
        output req_ready, ea_valid, ea, ea_last, ea_misalign, ea_oob, busy
    );
endinterface

// File: rtl/any1_agen_seq.sv
// Effective-address generator.
// Modes: 00 base+disp, 01 base+disp+(index<<sc), 10 strided sequence, 11 behaves as 00.
// A strided request emits N = max(cnt,1) addresses, one per accepted output beat.
// The stride is stored once, and each following address is the previous one plus the stride.
// Optional feature: define ANY1_AGEN_BOUNDS_EN to flag every address above lim on ea_oob.
// Without that macro, ea_oob is tied low and lim is ignored.
module any1_agen_seq #(
    parameter int AWID = 64,
    parameter int CNTW = 8
) (
    input  logic           clk,
    input  logic           rst,
    any1_agen_seq_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [AWID-1:0] ea_q;
    logic [AWID-1:0] stride_q;
    logic [CNTW-1:0] remain_q;
    logic [1:0]      size_q;
    logic            ea_valid_q;
    logic            ea_last_q;
    logic            ea_mis_q;
    logic            ea_oob_q;

    logic            req_ready_c;
    logic            accept;
    logic            beat;
    logic            multi;
    logic [AWID-1:0] scaled;
    logic [AWID-1:0] first_ea;
    logic [AWID-1:0] next_ea;
    logic            first_oob;
    logic            next_oob;

    // An address is misaligned when any of its low 'size' bits is set.
    function automatic logic misaligned(input logic [AWID-1:0] a, input logic [1:0] s);
        case (s)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return |a[1:0];
            default: return |a[2:0];
        endcase
    endfunction

    assign scaled   = bus.index << bus.sc;
    assign multi    = (bus.mode == 2'b10) && (bus.cnt > CNTW'(1));
    assign first_ea = (bus.mode == 2'b01) ? (bus.base + bus.disp + scaled)
                                          : (bus.base + bus.disp);
    assign next_ea  = ea_q + stride_q;
    assign accept   = bus.req_valid && req_ready_c;
    assign beat     = ea_valid_q && bus.ea_ready;

`ifdef ANY1_AGEN_BOUNDS_EN
    logic [AWID-1:0] lim_q;

    // Keep the bound of the accepted request so every strided element is checked against it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lim_q <= '0;
        end else if (accept) begin
            lim_q <= bus.lim;
        end
    end

    assign first_oob = first_ea > bus.lim;
    assign next_oob  = next_ea > lim_q;
`else
    assign first_oob = 1'b0;
    assign next_oob  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Enter GEN only for multi-element strided requests, and leave when the final element is taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && multi)     state_nxt = GEN;
            GEN:  if (beat && ea_last_q)   state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs.
    // A new request can enter only while idle and the result slot is free or draining.
    always_comb begin
        req_ready_c     = (state == IDLE) && (!ea_valid_q || bus.ea_ready);
        bus.req_ready   = req_ready_c;
        bus.busy        = (state == GEN) || ea_valid_q;
        bus.ea_valid    = ea_valid_q;
        bus.ea          = ea_q;
        bus.ea_last     = ea_last_q;
        bus.ea_misalign = ea_mis_q;
        bus.ea_oob      = ea_oob_q;
    end

    // Result datapath.
    // Load the first address on accept, step by the stored stride on each taken beat, and hold while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ea_valid_q <= 1'b0;
            ea_q       <= '0;
            ea_last_q  <= 1'b0;
            ea_mis_q   <= 1'b0;
            ea_oob_q   <= 1'b0;
            stride_q   <= '0;
            remain_q   <= '0;
            size_q     <= '0;
        end else if (accept) begin
            ea_valid_q <= 1'b1;
            ea_q       <= first_ea;
            ea_last_q  <= !multi;
            ea_mis_q   <= misaligned(first_ea, bus.size);
            ea_oob_q   <= first_oob;
            stride_q   <= scaled;
            remain_q   <= multi ? (bus.cnt - CNTW'(1)) : '0;
            size_q     <= bus.size;
        end else if (beat) begin
            if (ea_last_q) begin
                ea_valid_q <= 1'b0;
            end else begin
                ea_q      <= next_ea;
                remain_q  <= remain_q - CNTW'(1);
                ea_last_q <= (remain_q == CNTW'(1));
                ea_mis_q  <= misaligned(next_ea, size_q);
                ea_oob_q  <= next_oob;
            end
        end
    end

endmodule

// File: tb/tb_any1_agen_seq.sv
// Self-checking bench for any1_agen_seq.
// Contents:
//   - a table of single-result requests issued back to back;
//   - hand-written strided, stall and reset sequences;
//   - a randomized phase checked against a beat-queue reference model.
// Expected ea_oob follows ANY1_AGEN_BOUNDS_EN when the bench is built with the same define.
module tb_any1_agen_seq;

`ifdef ANY1_AGEN_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    any1_agen_seq_if #(.AWID(64), .CNTW(8)) bus ();

    any1_agen_seq #(.AWID(64), .CNTW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [63:0] base;
        logic [63:0] index;
        logic [63:0] disp;
        logic [2:0]  sc;
        logic [7:0]  cnt;
        logic [1:0]  size;
        logic [63:0] lim;
        logic [63:0] exp_ea;
        logic        exp_mis;
        logic        exp_oob;
    } vec_t;

    typedef struct {
        logic [63:0] ea;
        logic        last;
        logic        mis;
        logic        oob;
        logic        multi;
    } beat_t;

    localparam int NVEC = 9;
    vec_t  vecs [NVEC];
    beat_t q [$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic [63:0] base,
                                 input logic [63:0] index, input logic [63:0] disp,
                                 input logic [2:0] sc, input logic [7:0] cnt,
                                 input logic [1:0] size, input logic [63:0] lim);
        bus.mode      = mode;
        bus.base      = base;
        bus.index     = index;
        bus.disp      = disp;
        bus.sc        = sc;
        bus.cnt       = cnt;
        bus.size      = size;
        bus.lim       = lim;
        bus.req_valid = 1'b1;
    endtask

    function automatic vec_t mkvec(input logic [1:0] mode, input logic [63:0] base,
                                   input logic [63:0] index, input logic [63:0] disp,
                                   input logic [2:0] sc, input logic [7:0] cnt,
                                   input logic [1:0] size, input logic [63:0] lim,
                                   input logic [63:0] exp_ea, input logic exp_mis,
                                   input logic exp_oob);
        vec_t v;
        v.mode = mode;  v.base = base;  v.index = index;  v.disp = disp;
        v.sc = sc;  v.cnt = cnt;  v.size = size;  v.lim = lim;
        v.exp_ea = exp_ea;  v.exp_mis = exp_mis;  v.exp_oob = exp_oob;
        return v;
    endfunction

    // Reference address of element k, computed directly from the addressing rules.
    function automatic logic [63:0] elem_ea(input logic [1:0] mode, input logic [63:0] base,
                                            input logic [63:0] index, input logic [63:0] disp,
                                            input logic [2:0] sc, input int k);
        logic [63:0] stride;
        stride = index << sc;
        case (mode)
            2'b01:   return base + disp + stride;
            2'b10:   return base + disp + stride * 64'(k);
            default: return base + disp;
        endcase
    endfunction

    function automatic logic is_mis(input logic [63:0] a, input logic [1:0] size);
        return (a & ((64'd1 << size) - 64'd1)) != 64'd0;
    endfunction

    // Issue one strided request, then take elements using the ea_ready pattern (bit c = cycle c).
    task automatic run_strided(input string name, input logic [63:0] base, input logic [63:0] disp,
                               input logic [63:0] index, input logic [2:0] sc, input int n,
                               input logic [1:0] size, input logic [63:0] lim,
                               input logic [15:0] pat);
        int          k;
        logic        rdy;
        logic [63:0] e;
        applyStimulus(2'b10, base, index, disp, sc, 8'(n), size, lim);
        bus.ea_ready = 1'b1;
        #1 checkOutput({name, "_req_ready_idle"}, {63'd0, bus.req_ready}, 64'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        k = 0;
        for (int c = 0; c < 16 && k < n; c++) begin
            e = elem_ea(2'b10, base, index, disp, sc, k);
            checkOutput({name, "_ea_valid"}, {63'd0, bus.ea_valid}, 64'd1);
            checkOutput({name, "_ea"}, bus.ea, e);
            checkOutput({name, "_ea_last"}, {63'd0, bus.ea_last}, {63'd0, k == n - 1});
            checkOutput({name, "_ea_misalign"}, {63'd0, bus.ea_misalign}, {63'd0, is_mis(e, size)});
            checkOutput({name, "_ea_oob"}, {63'd0, bus.ea_oob}, {63'd0, BOUNDS && (e > lim)});
            rdy = pat[c];
            bus.ea_ready = rdy;
            #1;
            checkOutput({name, "_req_ready_gen"}, {63'd0, bus.req_ready}, 64'd0);
            checkOutput({name, "_busy"}, {63'd0, bus.busy}, 64'd1);
            if (rdy) k++;
            @(negedge clk);
        end
        bus.ea_ready = 1'b1;
        #1;
        checkOutput({name, "_done_valid"}, {63'd0, bus.ea_valid}, 64'd0);
        checkOutput({name, "_done_busy"}, {63'd0, bus.busy}, 64'd0);
        checkOutput({name, "_done_req_ready"}, {63'd0, bus.req_ready}, 64'd1);
    endtask

    initial begin
        logic        exp_rdy;
        logic [1:0]  rmode;
        logic [63:0] rbase, rindex, rdisp, rlim, e;
        logic [2:0]  rsc;
        logic [7:0]  rcnt;
        logic [1:0]  rsize;
        int          nel;

        n_cmp = 0;
        n_fail = 0;

        vecs[0] = mkvec(2'b01, 64'h1000, 64'd3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 8'd0, 2'd0, ALL1,
                        64'h1010, 1'b0, 1'b0);
        vecs[1] = mkvec(2'b00, ALL1, 64'd0, 64'd2, 3'd0, 8'd0, 2'd0, ALL1,
                        64'h1, 1'b0, 1'b0);
        vecs[2] = mkvec(2'b00, 64'h1000, 64'd0, 64'd6, 3'd0, 8'd0, 2'd2, 64'h1005,
                        64'h1006, 1'b1, 1'b1);
        vecs[3] = mkvec(2'b11, 64'h3000, 64'd5, 64'h10, 3'd2, 8'd0, 2'd3, 64'h3000,
                        64'h3010, 1'b0, 1'b1);
        vecs[4] = mkvec(2'b01, 64'h0, 64'h8000_0000_0000_0001, 64'h0, 3'd1, 8'd0, 2'd1, 64'h1,
                        64'h2, 1'b0, 1'b1);
        vecs[5] = mkvec(2'b01, 64'h1, 64'h0, 64'h0, 3'd7, 8'd0, 2'd1, 64'h1,
                        64'h1, 1'b1, 1'b0);
        vecs[6] = mkvec(2'b00, 64'h2000, 64'h0, 64'h0, 3'd0, 8'd0, 2'd3, 64'h2000,
                        64'h2000, 1'b0, 1'b0);
        vecs[7] = mkvec(2'b10, 64'h4004, 64'd9, 64'h0, 3'd0, 8'd1, 2'd2, ALL1,
                        64'h4004, 1'b0, 1'b0);
        vecs[8] = mkvec(2'b10, 64'h5000, 64'd7, 64'h3, 3'd0, 8'd0, 2'd1, 64'h5002,
                        64'h5003, 1'b1, 1'b1);

        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.ea_ready  = 1'b0;
        applyStimulus(2'b00, 64'd0, 64'd0, 64'd0, 3'd0, 8'd0, 2'd0, 64'd0);
        bus.req_valid = 1'b0;
        #3 rst = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rst_ea_valid", {63'd0, bus.ea_valid}, 64'd0);
        checkOutput("rst_ea", bus.ea, 64'd0);
        checkOutput("rst_ea_last", {63'd0, bus.ea_last}, 64'd0);
        checkOutput("rst_ea_misalign", {63'd0, bus.ea_misalign}, 64'd0);
        checkOutput("rst_ea_oob", {63'd0, bus.ea_oob}, 64'd0);
        checkOutput("rst_busy", {63'd0, bus.busy}, 64'd0);
        rst = 1'b1;
        #1 checkOutput("rst_release_req_ready", {63'd0, bus.req_ready}, 64'd1);

        // Back-to-back single-result requests, one result per cycle.
        bus.ea_ready = 1'b1;
        for (int i = 0; i <= NVEC; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checkOutput($sformatf("vec%0d_ea_valid", i - 1), {63'd0, bus.ea_valid}, 64'd1);
                checkOutput($sformatf("vec%0d_ea", i - 1), bus.ea, vecs[i-1].exp_ea);
                checkOutput($sformatf("vec%0d_ea_last", i - 1), {63'd0, bus.ea_last}, 64'd1);
                checkOutput($sformatf("vec%0d_ea_misalign", i - 1), {63'd0, bus.ea_misalign},
                            {63'd0, vecs[i-1].exp_mis});
                checkOutput($sformatf("vec%0d_ea_oob", i - 1), {63'd0, bus.ea_oob},
                            {63'd0, BOUNDS && vecs[i-1].exp_oob});
            end
            if (i < NVEC) begin
                applyStimulus(vecs[i].mode, vecs[i].base, vecs[i].index, vecs[i].disp,
                              vecs[i].sc, vecs[i].cnt, vecs[i].size, vecs[i].lim);
            end else begin
                bus.req_valid = 1'b0;
            end
            #1 checkOutput($sformatf("vec%0d_req_ready", i), {63'd0, bus.req_ready}, 64'd1);
        end
        @(negedge clk);
        checkOutput("table_drain_valid", {63'd0, bus.ea_valid}, 64'd0);

        // Four strided elements taken on consecutive cycles.
        run_strided("stride4", 64'h2000, 64'h0, 64'd4, 3'd1, 4, 2'd0, ALL1, 16'hFFFF);

        // A three-cycle stall on the second element, with per-element bound flags.
        run_strided("stall", 64'h8000, 64'h10, 64'd1, 3'd4, 5, 2'd3, 64'h8030, 16'b1111_1111_1111_0001);

        // Reset asserted while the second of four elements is presented.
        applyStimulus(2'b10, 64'h9000, 64'd8, 64'h0, 3'd0, 8'd4, 2'd0, ALL1);
        bus.ea_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        checkOutput("rstmid_e0", bus.ea, 64'h9000);
        @(negedge clk);
        checkOutput("rstmid_e1", bus.ea, 64'h9008);
        rst = 1'b0;
        #1;
        checkOutput("rstmid_ea_valid", {63'd0, bus.ea_valid}, 64'd0);
        checkOutput("rstmid_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("rstmid_ea", bus.ea, 64'd0);
        checkOutput("rstmid_ea_last", {63'd0, bus.ea_last}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 checkOutput("rstmid_req_ready", {63'd0, bus.req_ready}, 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("rstmid_no_resume", {63'd0, bus.ea_valid}, 64'd0);
            checkOutput("rstmid_idle_busy", {63'd0, bus.busy}, 64'd0);
        end

        // Randomized traffic against the beat-queue model, with a drain at the end.
        q.delete();
        for (int cyc = 0; cyc < 700; cyc++) begin
            @(negedge clk);
            if (cyc >= 640) begin
                bus.req_valid = 1'b0;
                bus.ea_ready  = 1'b1;
            end else begin
                bus.ea_ready = ($urandom_range(0, 3) != 0);
                rmode  = 2'($urandom_range(0, 3));
                rbase  = {$urandom, $urandom};
                rindex = ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 64)) : {$urandom, $urandom};
                rdisp  = {$urandom, $urandom};
                rsc    = 3'($urandom_range(0, 7));
                rcnt   = 8'($urandom_range(0, 5));
                rsize  = 2'($urandom_range(0, 3));
                rlim   = rbase + rdisp + 64'($urandom_range(0, 512)) - 64'd256;
                applyStimulus(rmode, rbase, rindex, rdisp, rsc, rcnt, rsize, rlim);
                bus.req_valid = ($urandom_range(0, 1) != 0);
            end
            #1;
            exp_rdy = (q.size() == 0) || (q.size() == 1 && !q[0].multi && bus.ea_ready);
            checkOutput("rnd_req_ready", {63'd0, bus.req_ready}, {63'd0, exp_rdy});
            checkOutput("rnd_ea_valid", {63'd0, bus.ea_valid}, {63'd0, q.size() != 0});
            checkOutput("rnd_busy", {63'd0, bus.busy}, {63'd0, q.size() != 0});
            if (q.size() != 0) begin
                checkOutput("rnd_ea", bus.ea, q[0].ea);
                checkOutput("rnd_ea_last", {63'd0, bus.ea_last}, {63'd0, q[0].last});
                checkOutput("rnd_ea_misalign", {63'd0, bus.ea_misalign}, {63'd0, q[0].mis});
                checkOutput("rnd_ea_oob", {63'd0, bus.ea_oob}, {63'd0, q[0].oob});
                if (bus.ea_ready) void'(q.pop_front());
            end
            if (bus.req_valid && exp_rdy) begin
                nel = (bus.mode == 2'b10) ? ((bus.cnt == 8'd0) ? 1 : int'(bus.cnt)) : 1;
                for (int k = 0; k < nel; k++) begin
                    beat_t b;
                    e       = elem_ea(bus.mode, bus.base, bus.index, bus.disp, bus.sc, k);
                    b.ea    = e;
                    b.last  = (k == nel - 1);
                    b.mis   = is_mis(e, bus.size);
                    b.oob   = BOUNDS && (e > bus.lim);
                    b.multi = (nel > 1);
                    q.push_back(b);
                end
            end
        end
        checkOutput("rnd_drained", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
